// File: rtl/hamming_pkg.sv
// Shared definitions for the 32-bit Hamming SECDED path (encoder and decoder).
// Holds the codeword geometry, the data-bit to codeword-position map, the
// beat classification enum and the helpers that work on whole codewords.
package hamming_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 6;
    localparam int CW_W   = 39;

    // Codeword position of each data bit. Positions 1, 2, 4, 8, 16 and 32
    // carry check bits; position 0 carries overall even parity.
    localparam logic [5:0] DATA_POS [DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,
        6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
        6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24,
        6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31,
        6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_CORR   = 2'd1,
        ST_UNCORR = 2'd2
    } status_e;

    // Pull the payload out of a codeword without any correction.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

    // Classify a beat from its syndrome and overall parity.
    // A nonzero syndrome with odd parity beyond the last position can only
    // come from three or more flips, so it is reported as uncorrectable.
    function automatic status_e classify(input logic [PAR_W-1:0] syn, input logic par);
        status_e st;
        if (syn == '0) begin
            st = par ? ST_CORR : ST_CLEAN;
        end else if (!par) begin
            st = ST_UNCORR;
        end else if (syn > 6'(CW_W - 1)) begin
            st = ST_UNCORR;
        end else begin
            st = ST_CORR;
        end
        return st;
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Streaming bus for the SECDED decoder: codeword input handshake and
// corrected-data output handshake with its error flags.
//   in_valid/in_ready/in_cw            : codeword stream into the decoder
//   out_valid/out_ready/out_data       : corrected payload stream out
//   out_corrected/out_uncorrectable    : per-beat status flags
// The slave modport is the decoder; master is the surrounding logic.
interface hamming_secded_decoder_if
    import hamming_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corrected;
    logic              out_uncorrectable;

    modport slave (
        input  in_valid,
        input  in_cw,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_corrected,
        output out_uncorrectable
    );

    modport master (
        output in_valid,
        output in_cw,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_corrected,
        input  out_uncorrectable
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 39-bit codeword.
//   i_cw  : codeword, bit 0 overall parity, bits 1..38 Hamming positions
//   o_syn : bit k is the XOR of every position whose index has bit k set
//   o_par : XOR of all 39 bits (1 means odd parity)
// The encoder reuses this block to compute its check bits.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [PAR_W-1:0] o_syn,
    output logic             o_par
);

    always_comb begin
        o_syn = '0;
        for (int p = 1; p < CW_W; p++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (p[k]) begin
                    o_syn[k] = o_syn[k] ^ i_cw[p];
                end
            end
        end
        o_par = ^i_cw;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage streaming SECDED decoder for the 32-bit Hamming path.
//   clk          : sole clock, rising edge
//   rst          : synchronous active-high reset
//   bus          : codeword in / corrected data out (slave modport)
//   cnt_clear    : synchronous clear of both error counters
//   corr_count   : saturating count of delivered corrected beats
//   uncorr_count : saturating count of delivered uncorrectable beats
// Stage 1 registers the codeword with its syndrome and parity; stage 2
// corrects, extracts the payload and registers the outputs. Both stages
// advance together only when the output register is empty or being taken.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    hamming_secded_decoder_if.slave bus,
    input  logic                   cnt_clear,
    output logic [CNT_W-1:0]       corr_count,
    output logic [CNT_W-1:0]       uncorr_count
);

    logic              w_adv;
    logic              w_out_hs;
    logic [PAR_W-1:0]  w_syn;
    logic              w_par;

    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s1_par;

    status_e           w_status;
    logic [CW_W-1:0]   w_flip;
    logic [CW_W-1:0]   w_fixed;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_corr;
    logic              r_out_uncorr;

    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    assign w_adv    = !r_out_valid || bus.out_ready;
    assign w_out_hs = r_out_valid && bus.out_ready;

    assign bus.in_ready          = w_adv;
    assign bus.out_valid         = r_out_valid;
    assign bus.out_data          = r_out_data;
    assign bus.out_corrected     = r_out_corr;
    assign bus.out_uncorrectable = r_out_uncorr;
    assign corr_count            = r_corr_cnt;
    assign uncorr_count          = r_uncorr_cnt;

    hamming_syndrome u_syndrome (
        .i_cw  (bus.in_cw),
        .o_syn (w_syn),
        .o_par (w_par)
    );

    // Stage 1: capture the codeword and its checks. The data fields load
    // even on bubbles; only the valid bit matters downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_cw    <= bus.in_cw;
            r_s1_syn   <= w_syn;
            r_s1_par   <= w_par;
        end
    end

    // Stage 2 datapath. A correctable beat with syndrome 0 means only the
    // parity bit flipped, so nothing in the payload needs touching. When the
    // syndrome names a check-bit position the flip lands outside the payload
    // and extraction is unaffected.
    always_comb begin
        w_status = classify(r_s1_syn, r_s1_par);
        w_flip   = '0;
        if (w_status == ST_CORR && r_s1_syn != '0) begin
            w_flip = CW_W'(1) << r_s1_syn;
        end
        w_fixed = r_s1_cw ^ w_flip;
        w_data  = extract_data(w_fixed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_adv) begin
            r_out_valid  <= r_s1_valid;
            r_out_data   <= w_data;
            r_out_corr   <= r_s1_valid && (w_status == ST_CORR);
            r_out_uncorr <= r_s1_valid && (w_status == ST_UNCORR);
        end
    end

    // Counters step on delivered beats only; clear wins over an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clear) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_out_hs && r_out_corr && !(&r_corr_cnt)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (w_out_hs && r_out_uncorr && !(&r_uncorr_cnt)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Streaming SECDED decoder for the 32-bit Hamming path. It sits directly downstream of the encoder and error-injection stage.
- Accepts 39-bit codewords over a valid/ready handshake. It corrects single-bit errors, flags double-bit errors and delivers 32-bit data through a 2-stage pipeline.
- Keeps saturating correctable and uncorrectable error counters for the top level.

Parameters:
- DATA_W, 32, payload width; fixed, other values not supported.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword on in_cw is valid.
- in_ready  out  1  decoder accepts in_cw this cycle.
- in_cw  in  39  codeword. Bit 0 is overall even parity; bits 1..38 are Hamming positions 1..38.
- out_valid  out  1  out_data and its flags are valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  32  corrected payload.
- out_corrected  out  1  a single-bit error was corrected, or parity bit 0 was wrong.
- out_uncorrectable  out  1  double error or invalid syndrome; out_data is uncorrected.
- cnt_clear  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  saturating count of out_corrected beats.
- uncorr_count  out  CNT_W  saturating count of out_uncorrectable beats.

Behaviour:
- Codeword layout:
  - Check bits sit at positions 1, 2, 4, 8, 16, 32.
  - Data bits 0..31 fill the remaining positions 3, 5, 6, 7, 9..15, 17..31, 33..38 in ascending order.
- Stage 1 (S1):
  - Syndrome s[5:0]: bit k is the XOR of all positions p in 1..38 with bit k of p set.
  - Overall parity P is the XOR of all 39 bits.
  - S1 registers the codeword, s, P and the valid bit.
- Stage 2 (S2) classifies the beat and registers the outputs:
  - s==0 & P==0: clean; data passes through.
  - s==0 & P==1: bit 0 is in error; data passes through; corrected=1.
  - s!=0 & P==1 & s<=38: flip position s, then extract data; corrected=1. If s is a check-bit position, data is unchanged but corrected=1.
  - s!=0 & P==1 & s>38: uncorrectable=1.
  - s!=0 & P==0: uncorrectable=1 (double error).
  - When uncorrectable=1, data is extracted raw.
- Handshake:
  - adv = !out_valid | out_ready. The whole pipeline advances only when adv=1.
  - in_ready = adv, so in_ready is combinational from out_ready.
  - A beat transfers when in_valid & in_ready.
  - Latency is exactly 2 cycles from accept to out_valid when there are no stalls. Throughput is 1 beat/cycle.
- Stall:
  - While out_valid & !out_ready, the S1 and S2 registers and all outputs hold stable.
  - The output must not change until accepted.
- Bubbles: S1 valid=0 propagates so out_valid deasserts; data registers may hold stale values.
- Counters:
  - Each counter increments once per output handshake (out_valid & out_ready) carrying its flag.
  - Counters saturate at all-ones.
  - cnt_clear has priority over an increment in the same cycle; the result is 0.
- Reset:
  - out_valid=0, S1 valid=0, out_data=0, flags=0, counters=0. in_ready=1 during and after reset.
  - In-flight beats are discarded when reset is asserted mid-stream.
- Flag exclusivity: out_corrected and out_uncorrectable are never both 1.

Decomposition:
- hamming_pkg holds:
  - DATA_W=32, PAR_W=6, CW_W=39.
  - The data-to-position map as a constant array.
  - A status enum: CLEAN, CORR, UNCORR.
- The encoder and this decoder share hamming_pkg.
- One combinational sub-module, hamming_syndrome (cw in; s and P out), is instantiated in S1. The encoder reuses it for check-bit generation.

Test Plan:
- Clean stream: encode 32'd12, 32'd8456, 32'hFFFFFFFF back-to-back with out_ready=1 -> the same data appears 2 cycles later on consecutive cycles; flags 0; counters 0.
- Single error: 32'd8456 with position 5 flipped -> out_data=32'd8456, corrected=1, corr_count=1. Repeat with bit 0 flipped -> same data, corrected=1, corr_count=2.
- Double error: 32'd12 with positions 3 and 6 flipped -> uncorrectable=1, out_data != 12, uncorr_count=1.
- Backpressure: 4 beats with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, no beat lost or duplicated, output stable while stalled, order preserved.
- Saturation/clear:
  - Preload with 65535 single-error beats, then one more -> corr_count stays 16'hFFFF.
  - cnt_clear together with an error handshake -> both counters 0.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 the next cycle, no stale beat emitted afterwards, counters 0.
